// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: single-outstanding issue/retire controller in front of fp_unit.
module fp_issue_ctrl #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_i_valid,
  output logic              iss_o_ready,
  input  logic [16:0]       iss_i_op,
  input  logic [1:0]        iss_i_fmt,
  input  logic [2:0]        iss_i_rm,
  input  logic [TAG_W-1:0]  iss_i_rd,
  input  logic [31:0]       iss_i_data1,
  input  logic [31:0]       iss_i_data2,
  input  logic [31:0]       iss_i_data3,
  output logic [16:0]       fpu_o_op,
  output logic [1:0]        fpu_o_fmt,
  output logic [2:0]        fpu_o_rm,
  output logic [31:0]       fpu_o_data1,
  output logic [31:0]       fpu_o_data2,
  output logic [31:0]       fpu_o_data3,
  output logic              fpu_o_enable,
  input  logic [31:0]       fpu_i_result,
  input  logic [4:0]        fpu_i_flags,
  input  logic              fpu_i_ready,
  output logic              wb_o_valid,
  input  logic              wb_i_ready,
  output logic [TAG_W-1:0]  wb_o_rd,
  output logic [31:0]       wb_o_data,
  output logic [4:0]        wb_o_flags,
  output logic              wb_o_timeout,
  input  logic              fflags_i_clear,
  output logic [4:0]        fflags_o_acc,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [16:0]        op_q, op_d;
  logic [1:0]         fmt_q, fmt_d;
  logic [2:0]         rm_q, rm_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic [31:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         flg_q, flg_d;
  logic               to_q, to_d;
  logic [4:0]         acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fmt_d   = fmt_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flg_d   = flg_q;
    to_d    = to_q;
    acc_d   = fflags_i_clear ? '0 : acc_q;
    case (state_q)
      S_IDLE: begin
        if (iss_i_valid) begin
          op_d  = iss_i_op;
          fmt_d = iss_i_fmt;
          rm_d  = iss_i_rm;
          rd_d  = iss_i_rd;
          d1_d  = iss_i_data1;
          d2_d  = iss_i_data2;
          d3_d  = iss_i_data3;
          if (|iss_i_op[16:2]) begin
            state_d = S_LAUNCH;
          end else begin
            res_d   = '0;
            flg_d   = '0;
            to_d    = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        if (fpu_i_ready) begin
          res_d   = fpu_i_result;
          flg_d   = fpu_i_flags;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_i_ready) begin
          res_d   = fpu_i_result;
          flg_d   = fpu_i_flags;
          to_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          flg_d   = 5'b10000;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (wb_i_ready) begin
          // clear and retire in the same cycle: old bits dropped, retiring bits kept
          acc_d   = (fflags_i_clear ? 5'b00000 : acc_q) | flg_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fmt_q   <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      to_q    <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fmt_q   <= fmt_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      to_q    <= to_d;
      acc_q   <= acc_d;
    end
  end

  assign iss_o_ready  = (state_q == S_IDLE) && !reset;
  assign fpu_o_enable = (state_q == S_LAUNCH);
  assign fpu_o_op     = ((state_q == S_LAUNCH) || (state_q == S_WAIT)) ? op_q : '0;
  assign fpu_o_fmt    = fmt_q;
  assign fpu_o_rm     = rm_q;
  assign fpu_o_data1  = d1_q;
  assign fpu_o_data2  = d2_q;
  assign fpu_o_data3  = d3_q;
  assign wb_o_valid   = (state_q == S_DONE);
  assign wb_o_rd      = rd_q;
  assign wb_o_data    = res_q;
  assign wb_o_flags   = flg_q;
  assign wb_o_timeout = to_q;
  assign fflags_o_acc = acc_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Randomized self-checking bench for fp_issue_ctrl.
module tb_fp_issue_ctrl;

  localparam int unsigned TAG_W   = 5;
  localparam int unsigned TIMEOUT = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              iss_i_valid = 1'b0;
  logic              iss_o_ready;
  logic [16:0]       iss_i_op = '0;
  logic [1:0]        iss_i_fmt = '0;
  logic [2:0]        iss_i_rm = '0;
  logic [TAG_W-1:0]  iss_i_rd = '0;
  logic [31:0]       iss_i_data1 = '0, iss_i_data2 = '0, iss_i_data3 = '0;
  logic [16:0]       fpu_o_op;
  logic [1:0]        fpu_o_fmt;
  logic [2:0]        fpu_o_rm;
  logic [31:0]       fpu_o_data1, fpu_o_data2, fpu_o_data3;
  logic              fpu_o_enable;
  logic [31:0]       fpu_i_result = '0;
  logic [4:0]        fpu_i_flags = '0;
  logic              fpu_i_ready = 1'b0;
  logic              wb_o_valid;
  logic              wb_i_ready = 1'b0;
  logic [TAG_W-1:0]  wb_o_rd;
  logic [31:0]       wb_o_data;
  logic [4:0]        wb_o_flags;
  logic              wb_o_timeout;
  logic              fflags_i_clear = 1'b0;
  logic [4:0]        fflags_o_acc;
  logic              o_busy;

  fp_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .iss_i_valid(iss_i_valid), .iss_o_ready(iss_o_ready), .iss_i_op(iss_i_op),
    .iss_i_fmt(iss_i_fmt), .iss_i_rm(iss_i_rm), .iss_i_rd(iss_i_rd),
    .iss_i_data1(iss_i_data1), .iss_i_data2(iss_i_data2), .iss_i_data3(iss_i_data3),
    .fpu_o_op(fpu_o_op), .fpu_o_fmt(fpu_o_fmt), .fpu_o_rm(fpu_o_rm),
    .fpu_o_data1(fpu_o_data1), .fpu_o_data2(fpu_o_data2), .fpu_o_data3(fpu_o_data3),
    .fpu_o_enable(fpu_o_enable), .fpu_i_result(fpu_i_result), .fpu_i_flags(fpu_i_flags),
    .fpu_i_ready(fpu_i_ready), .wb_o_valid(wb_o_valid), .wb_i_ready(wb_i_ready),
    .wb_o_rd(wb_o_rd), .wb_o_data(wb_o_data), .wb_o_flags(wb_o_flags),
    .wb_o_timeout(wb_o_timeout), .fflags_i_clear(fflags_i_clear),
    .fflags_o_acc(fflags_o_acc), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [4:0]  m_acc  = '0;   // reference sticky flags

  // observations of the last transaction
  int unsigned      obs_lat, obs_en;
  logic             obs_rdy_idle, obs_fwd_ok, obs_busy_ok, obs_stable, obs_valid_after, obs_rdy_after;
  logic [TAG_W-1:0] obs_rd;
  logic [31:0]      obs_data;
  logic [4:0]       obs_flags, obs_acc;
  logic             obs_to;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int unsigned exp_lat(input logic [16:0] op, input int unsigned delay);
    if (!(|op[16:2])) return 1;
    if (delay <= TIMEOUT - 1) return delay + 2;
    return TIMEOUT + 1;
  endfunction

  // Issues one op and plays fp_unit (ready after `delay` cycles past launch) and
  // the writeback sink (stalls `stall` cycles); records what the DUT did.
  task automatic run_op(input logic [16:0] op, input logic [TAG_W-1:0] rd, input int unsigned delay,
                        input logic [31:0] res, input logic [4:0] flg, input int unsigned stall,
                        input logic clr);
    int unsigned cyc;
    logic [31:0] d1, d2, d3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    fmt = 2'($urandom); rm = 3'($urandom);
    obs_rdy_idle = iss_o_ready;
    iss_i_valid = 1'b1; iss_i_op = op; iss_i_fmt = fmt; iss_i_rm = rm; iss_i_rd = rd;
    iss_i_data1 = d1; iss_i_data2 = d2; iss_i_data3 = d3;
    step();
    cyc = 1; obs_en = 0; obs_fwd_ok = 1'b1; obs_busy_ok = 1'b1; obs_stable = 1'b1;
    while (!wb_o_valid && cyc < 300) begin
      if (fpu_o_enable) begin
        obs_en++;
        if (cyc != 1) obs_fwd_ok = 1'b0;
      end
      if (fpu_o_op !== op || fpu_o_fmt !== fmt || fpu_o_rm !== rm ||
          fpu_o_data1 !== d1 || fpu_o_data2 !== d2 || fpu_o_data3 !== d3) obs_fwd_ok = 1'b0;
      if (!o_busy || iss_o_ready) obs_busy_ok = 1'b0;
      iss_i_valid = 1'($urandom); iss_i_rd = TAG_W'($urandom); iss_i_op = 17'($urandom);
      wb_i_ready = 1'($urandom);
      fpu_i_ready  = (cyc - 1 == delay);
      fpu_i_result = fpu_i_ready ? res : $urandom;
      fpu_i_flags  = fpu_i_ready ? flg : 5'($urandom);
      step();
      cyc++;
    end
    obs_lat = cyc;
    obs_rd = wb_o_rd; obs_data = wb_o_data; obs_flags = wb_o_flags; obs_to = wb_o_timeout;
    for (int unsigned i = 0; i < stall; i++) begin
      if (fpu_o_enable) obs_en++;
      if (fpu_o_op !== 17'd0 || iss_o_ready || !o_busy) obs_busy_ok = 1'b0;
      wb_i_ready = 1'b0; fflags_i_clear = 1'b0;
      fpu_i_ready = 1'($urandom); fpu_i_result = $urandom; fpu_i_flags = 5'($urandom);
      iss_i_valid = 1'($urandom);
      step();
      if (!wb_o_valid || wb_o_rd !== obs_rd || wb_o_data !== obs_data ||
          wb_o_flags !== obs_flags || wb_o_timeout !== obs_to) obs_stable = 1'b0;
    end
    if (fpu_o_enable) obs_en++;
    if (fpu_o_op !== 17'd0 || iss_o_ready) obs_busy_ok = 1'b0;
    wb_i_ready = 1'b1; fflags_i_clear = clr; fpu_i_ready = 1'b0; iss_i_valid = 1'b0;
    step();
    wb_i_ready = 1'b0; fflags_i_clear = 1'b0;
    obs_valid_after = wb_o_valid; obs_rdy_after = iss_o_ready; obs_acc = fflags_o_acc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (iss_o_ready !== 1'b0) $display("FAIL reset_iss_ready: got %0b expected 0", iss_o_ready); else passed++;
    total++; if ({wb_o_valid, wb_o_rd, wb_o_data, wb_o_flags, wb_o_timeout} !== '0)
      $display("FAIL reset_wb: got %0h expected 0", {wb_o_valid, wb_o_rd, wb_o_data, wb_o_flags, wb_o_timeout}); else passed++;
    total++; if ({fpu_o_enable, fpu_o_op, fflags_o_acc, o_busy} !== '0)
      $display("FAIL reset_fpu_acc: got %0h expected 0", {fpu_o_enable, fpu_o_op, fflags_o_acc, o_busy}); else passed++;
    reset = 1'b0;
    step();
    total++; if (iss_o_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b expected 1", iss_o_ready); else passed++;
    m_acc = '0;
  endtask

  task automatic test_fadd();
    run_op(17'h0_8000 >> 1, 5'd7, 0, 32'h4040_0000, 5'b00000, 0, 1'b0);
    total++; if (obs_lat !== 2) $display("FAIL fadd_latency: got %0d expected 2", obs_lat); else passed++;
    total++; if (obs_data !== 32'h4040_0000) $display("FAIL fadd_data: got %0h expected 40400000", obs_data); else passed++;
    total++; if (obs_rd !== 5'd7) $display("FAIL fadd_rd: got %0d expected 7", obs_rd); else passed++;
    total++; if (obs_en !== 1 || !obs_fwd_ok) $display("FAIL fadd_launch: got en=%0d fwd=%0b expected en=1 fwd=1", obs_en, obs_fwd_ok); else passed++;
  endtask

  task automatic test_fmadd_wait();
    run_op(17'h1_0000, 5'd19, 5, 32'h1234_5678, 5'b00001, 0, 1'b0);
    m_acc = m_acc | 5'b00001;
    total++; if (obs_lat !== 7) $display("FAIL fmadd_latency: got %0d expected 7", obs_lat); else passed++;
    total++; if (obs_en !== 1) $display("FAIL fmadd_enable_count: got %0d expected 1", obs_en); else passed++;
    total++; if (obs_flags !== 5'b00001) $display("FAIL fmadd_flags: got %b expected 00001", obs_flags); else passed++;
    total++; if (obs_acc !== m_acc) $display("FAIL fmadd_acc: got %b expected %b", obs_acc, m_acc); else passed++;
    total++; if (!obs_busy_ok) $display("FAIL fmadd_busy: got %0b expected 1", obs_busy_ok); else passed++;
  endtask

  task automatic test_reset_in_wait();
    iss_i_valid = 1'b1; iss_i_op = 17'h0_0100; iss_i_rd = 5'd3;
    step();
    iss_i_valid = 1'b0; fpu_i_ready = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    total++; if ({iss_o_ready, wb_o_valid, o_busy, fpu_o_enable} !== 4'b0000)
      $display("FAIL rstwait_state: got %b expected 0000", {iss_o_ready, wb_o_valid, o_busy, fpu_o_enable}); else passed++;
    total++; if (fflags_o_acc !== 5'b00000) $display("FAIL rstwait_acc: got %b expected 00000", fflags_o_acc); else passed++;
    reset = 1'b0; fpu_i_ready = 1'b1; fpu_i_result = 32'hdead_beef; fpu_i_flags = 5'b11111;
    step(); step();
    fpu_i_ready = 1'b0;
    total++; if ({wb_o_valid, o_busy, fpu_o_enable, iss_o_ready} !== 4'b0001)
      $display("FAIL rstwait_late_ready: got %b expected 0001", {wb_o_valid, o_busy, fpu_o_enable, iss_o_ready}); else passed++;
    m_acc = '0;
  endtask

  task automatic test_timeout();
    run_op(17'h0_0400, 5'd11, TIMEOUT - 1, 32'hcafe_0001, 5'b00010, 0, 1'b0);
    m_acc = m_acc | 5'b00010;
    total++; if (obs_lat !== TIMEOUT + 1 || obs_to !== 1'b0 || obs_data !== 32'hcafe_0001)
      $display("FAIL last_wait_capture: got lat=%0d to=%0b data=%0h expected lat=%0d to=0 data=cafe0001", obs_lat, obs_to, obs_data, TIMEOUT + 1); else passed++;
    run_op(17'h0_0400, 5'd12, 1000, 32'hcafe_0002, 5'b00001, 0, 1'b0);
    m_acc = m_acc | 5'b10000;
    total++; if (obs_lat !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d expected %0d", obs_lat, TIMEOUT + 1); else passed++;
    total++; if ({obs_to, obs_flags, obs_data} !== {1'b1, 5'b10000, 32'd0})
      $display("FAIL timeout_wb: got to=%0b flags=%b data=%0h expected to=1 flags=10000 data=0", obs_to, obs_flags, obs_data); else passed++;
    total++; if (obs_acc !== m_acc) $display("FAIL timeout_acc: got %b expected %b", obs_acc, m_acc); else passed++;
  endtask

  task automatic test_wb_stall();
    run_op(17'h0_0020, 5'd25, 2, 32'h0bad_f00d, 5'b01000, 4, 1'b0);
    m_acc = m_acc | 5'b01000;
    total++; if (!obs_stable) $display("FAIL stall_stable: got %0b expected 1", obs_stable); else passed++;
    total++; if (!obs_busy_ok) $display("FAIL stall_not_ready: got %0b expected 1", obs_busy_ok); else passed++;
    total++; if ({obs_valid_after, obs_rdy_after} !== 2'b01)
      $display("FAIL stall_resume: got %b expected 01", {obs_valid_after, obs_rdy_after}); else passed++;
    total++; if (obs_data !== 32'h0bad_f00d || obs_rd !== 5'd25)
      $display("FAIL stall_data: got %0h/%0d expected bad f00d/25", obs_data, obs_rd); else passed++;
  endtask

  task automatic test_clear_handshake();
    fflags_i_clear = 1'b1;
    step();
    fflags_i_clear = 1'b0;
    m_acc = '0;
    total++; if (fflags_o_acc !== 5'b00000) $display("FAIL clear_idle: got %b expected 00000", fflags_o_acc); else passed++;
    run_op(17'h0_0004, 5'd1, 1, 32'h1, 5'b00001, 0, 1'b0);
    total++; if (obs_acc !== 5'b00001) $display("FAIL clear_prior_acc: got %b expected 00001", obs_acc); else passed++;
    run_op(17'h0_0008, 5'd2, 0, 32'h2, 5'b00100, 1, 1'b1);
    m_acc = 5'b00100;
    total++; if (obs_acc !== 5'b00100) $display("FAIL clear_with_handshake: got %b expected 00100", obs_acc); else passed++;
  endtask

  task automatic test_no_op();
    run_op(17'b0_0000_0000_0000_0011, 5'd30, 0, 32'hffff_ffff, 5'b11111, 0, 1'b0);
    total++; if (obs_lat !== 1 || obs_en !== 0) $display("FAIL noop_path: got lat=%0d en=%0d expected lat=1 en=0", obs_lat, obs_en); else passed++;
    total++; if ({obs_data, obs_flags, obs_to} !== '0 || obs_rd !== 5'd30)
      $display("FAIL noop_wb: got data=%0h flags=%b to=%0b rd=%0d expected 0/0/0/30", obs_data, obs_flags, obs_to, obs_rd); else passed++;
  endtask

  task automatic test_random();
    for (int unsigned n = 0; n < 30; n++) begin
      logic [16:0]      op;
      logic [TAG_W-1:0] rd;
      logic [31:0]      res, e_data;
      logic [4:0]       flg, e_flags;
      int unsigned      delay, stall;
      logic             clr, real_op, cap;
      op = 17'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) op[$urandom_range(2, 16)] = 1'b1;
      rd = TAG_W'($urandom); res = $urandom; flg = 5'($urandom);
      case ($urandom_range(0, 5))
        0:       delay = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
        default: delay = $urandom_range(0, 8);
      endcase
      stall = $urandom_range(0, 3);
      clr = ($urandom_range(0, 3) == 0);
      real_op = |op[16:2];
      cap = real_op && (delay <= TIMEOUT - 1);
      e_data  = cap ? res : 32'd0;
      e_flags = cap ? flg : (real_op ? 5'b10000 : 5'b00000);
      m_acc = (clr ? 5'b00000 : m_acc) | e_flags;
      run_op(op, rd, delay, res, flg, stall, clr);
      total++; if (obs_lat !== exp_lat(op, delay)) $display("FAIL rnd%0d_latency: got %0d expected %0d", n, obs_lat, exp_lat(op, delay)); else passed++;
      total++; if ({obs_rd, obs_data, obs_flags, obs_to} !== {rd, e_data, e_flags, real_op && !cap})
        $display("FAIL rnd%0d_wb: got rd=%0d data=%0h flags=%b to=%0b expected rd=%0d data=%0h flags=%b to=%0b",
                 n, obs_rd, obs_data, obs_flags, obs_to, rd, e_data, e_flags, real_op && !cap); else passed++;
      total++; if (obs_en !== (real_op ? 1 : 0) || !obs_fwd_ok || !obs_stable || !obs_busy_ok || !obs_rdy_idle)
        $display("FAIL rnd%0d_protocol: got en=%0d fwd=%0b stable=%0b busy=%0b rdy=%0b expected en=%0d and flags 1",
                 n, obs_en, obs_fwd_ok, obs_stable, obs_busy_ok, obs_rdy_idle, real_op ? 1 : 0); else passed++;
      total++; if (obs_acc !== m_acc) $display("FAIL rnd%0d_acc: got %b expected %b", n, obs_acc, m_acc); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fmadd_wait();
    test_reset_in_wait();
    test_timeout();
    test_wb_stall();
    test_clear_handshake();
    test_no_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
